// File: rtl/beep_pkg.sv
// beep_pkg: shared types, constants and helpers for the beep scheduler
//   state_e     scheduler FSM states
//   IDLE_OWNER  owner code reported while no note is active
//   TONE_*      named tone presets (15-bit counter start values)
package beep_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
    localparam logic [1:0] IDLE_OWNER = 2'd3;
    localparam int TONE_W = 15;
    localparam logic [TONE_W-1:0] TONE_REST = 15'h0000;
    localparam logic [TONE_W-1:0] TONE_M3 = 15'h625F;
    localparam logic [TONE_W-1:0] TONE_M5 = 15'h6715;
    localparam logic [TONE_W-1:0] TONE_H1 = 15'h6D55;
    // Lowest set index wins; IDLE_OWNER when nothing requests.
    function automatic logic [1:0] pick(input logic [2:0] r);
        return r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : IDLE_OWNER;
    endfunction
    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction
endpackage

// File: rtl/beep_sched_if.sv
// beep_sched_if: requester-side bus of the beep scheduler
//   req            3   level requests, bit 0 highest priority
//   tone0..tone2   15  tone preset per requester (0 = rest)
//   len0..len2     8   note length in beats per requester
//   gnt, done      3   one-hot single-cycle grant / completion pulses
//   busy           1   note playing or in inter-note gap
//   owner          2   current owner index, 3 when idle
interface beep_sched_if;
    import beep_pkg::*;
    logic [2:0] req;
    logic [TONE_W-1:0] tone0, tone1, tone2;
    logic [7:0] len0, len1, len2;
    logic [2:0] gnt, done;
    logic busy;
    logic [1:0] owner;
    modport master(output req, tone0, tone1, tone2, len0, len1, len2, input gnt, done, busy, owner);
    modport slave(input req, tone0, tone1, tone2, len0, len1, len2, output gnt, done, busy, owner);
endinterface

// File: rtl/beep_tone_gen.sv
// beep_tone_gen: prescaled preset counter that toggles the buzzer on each wrap
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      grant pulse: latch preset_i, restart prescaler, beep low
//   play_i      note active next cycle; low clears everything
//   preset_i    tone preset, 0 = rest (never toggles)
//   beep_o      buzzer drive, period CLK_DIV*2*(32768-preset) clk
module beep_tone_gen import beep_pkg::*; #(
    parameter int CLK_DIV = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              play_i,
    input  logic [TONE_W-1:0] preset_i,
    output logic              beep_o
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] div_q, div_d;
    logic [TONE_W-1:0] cnt_q, cnt_d, preset_q, preset_d;
    logic beep_q, beep_d, tick, wrap;
    always_comb begin
        tick = div_q == DIV_LAST;
        wrap = cnt_q == '1;
        div_d = (!play_i || load_i || tick) ? '0 : div_q + DW'(1);
        preset_d = load_i ? preset_i : play_i ? preset_q : '0;
        cnt_d = load_i ? preset_i : !play_i ? '0 : !tick ? cnt_q : wrap ? preset_q : cnt_q + TONE_W'(1);
        beep_d = (load_i || !play_i) ? 1'b0 : (tick && wrap && preset_q != '0) ? ~beep_q : beep_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
            preset_q <= '0;
            beep_q <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            preset_q <= preset_d;
            beep_q <= beep_d;
        end
    end
    assign beep_o = beep_q;
endmodule

// File: rtl/beep_sched.sv
// beep_sched: fixed-priority buzzer note scheduler (IDLE -> PLAY -> GAP)
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         beep_sched_if.slave: req/tone/len in, gnt/done/busy/owner out
//   beep_out_o  buzzer drive
// Define BEEP_SCHED_PREEMPT_EN to let a higher-priority request abort a
// playing note (no done, no gap, immediate regrant).
module beep_sched import beep_pkg::*; #(
    parameter int CLK_DIV  = 10,
    parameter int BEAT_DIV = 10_000_000,
    parameter int GAP_CYC  = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    beep_sched_if.slave  bus,
    output logic         beep_out_o
);
    localparam int BW = $clog2(BEAT_DIV + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    state_e state_q, state_d;
    logic [1:0] owner_q, owner_d, win;
    logic [7:0] len_q, len_d, beats_q, beats_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0] gnt_q, gnt_d, done_q, done_d;
    logic [TONE_W-1:0] preset;
    logic load, preempt, last;
    always_comb begin
        win = pick(bus.req);
`ifdef BEEP_SCHED_PREEMPT_EN
        preempt = state_q == PLAY && win < owner_q;
`else
        preempt = 1'b0;
`endif
        load = (state_q == IDLE && win != IDLE_OWNER) || preempt;
        // Last PLAY cycle: final cycle of the final beat, or immediately for len 0.
        last = len_q == 8'd0 || (beat_q == BEAT_LAST && beats_q == len_q - 8'd1);
        preset = win == 2'd0 ? bus.tone0 : win == 2'd1 ? bus.tone1 : bus.tone2;
        state_d = state_q;
        owner_d = owner_q;
        len_d = len_q;
        beat_d = beat_q;
        beats_d = beats_q;
        gap_d = gap_q;
        gnt_d = '0;
        done_d = '0;
        if (load) begin
            state_d = PLAY;
            owner_d = win;
            len_d = win == 2'd0 ? bus.len0 : win == 2'd1 ? bus.len1 : bus.len2;
            beat_d = '0;
            beats_d = '0;
            gnt_d = onehot(win);
        end else if (state_q == PLAY && last) begin
            done_d = onehot(owner_q);
            state_d = len_q == 8'd0 ? IDLE : GAP;
            owner_d = len_q == 8'd0 ? IDLE_OWNER : owner_q;
        end else if (state_q == PLAY) begin
            beat_d = beat_q == BEAT_LAST ? '0 : beat_q + BW'(1);
            beats_d = beat_q == BEAT_LAST ? beats_q + 8'd1 : beats_q;
        end else if (state_q == GAP) begin
            state_d = gap_q == GAP_LAST ? IDLE : GAP;
            owner_d = gap_q == GAP_LAST ? IDLE_OWNER : owner_q;
            gap_d = gap_q == GAP_LAST ? '0 : gap_q + GW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= IDLE_OWNER;
            len_q <= '0;
            beat_q <= '0;
            beats_q <= '0;
            gap_q <= '0;
            gnt_q <= '0;
            done_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            len_q <= len_d;
            beat_q <= beat_d;
            beats_q <= beats_d;
            gap_q <= gap_d;
            gnt_q <= gnt_d;
            done_q <= done_d;
        end
    end
    // Driven from next state so the buzzer drops on the very edge PLAY is left.
    beep_tone_gen #(.CLK_DIV(CLK_DIV)) u_tone (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .play_i   (state_d == PLAY),
        .preset_i (preset),
        .beep_o   (beep_out_o)
    );
    assign bus.gnt = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = state_q != IDLE;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_beep_sched.sv
// tb_beep_sched: scoreboard bench for beep_sched (CLK_DIV=2, BEAT_DIV=20, GAP_CYC=5)
module tb_beep_sched;
    import beep_pkg::*;
    typedef struct packed {
        logic       dn;
        logic [1:0] idx;
        int         cyc;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic beep;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    ev_t exp_q[$];
    beep_sched_if bus();
    beep_sched #(.CLK_DIV(2), .BEAT_DIV(20), .GAP_CYC(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .beep_out_o (beep)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every gnt/done pulse is popped against the next expected event.
    always @(negedge clk) begin : mon
        ev_t e;
        logic [5:0] ev;
        ev = {bus.done, bus.gnt};
        if (rst_n) for (int k = 0; k < 6; k++) if (ev[k] === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %s[%0d] at cyc %0d, required no event", k >= 3 ? "done" : "gnt", k % 3, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.dn !== (k >= 3) || e.idx !== 2'(k % 3) || e.cyc !== cyc) begin
                    fails++;
                    $display("FAIL sb_event: got %s[%0d]@%0d, required %s[%0d]@%0d", k >= 3 ? "done" : "gnt", k % 3, cyc, e.dn ? "done" : "gnt", e.idx, e.cyc);
                end
            end
        end
    end

    task automatic push(input logic dn, input logic [1:0] idx, input int c);
        exp_q.push_back(ev_t'{dn: dn, idx: idx, cyc: c});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset;
        int k;
        rst_n = 1'b0;
        bus.req = '0;
        bus.tone0 = '0; bus.tone1 = '0; bus.tone2 = '0;
        bus.len0 = '0; bus.len1 = '0; bus.len2 = '0;
        repeat (2) @(negedge clk);
        tests++; if (bus.gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b, required 000", bus.gnt); end
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL reset_done: got %b, required 000", bus.done); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        tests++; if (bus.owner !== 2'd3) begin fails++; $display("FAIL reset_owner: got %0d, required 3", bus.owner); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL reset_beep: got %b, required 0", beep); end
        // Request pending across reset release; zero-length note.
        bus.req = 3'b100; bus.tone2 = TONE_M3; bus.len2 = 8'd0;
        k = cyc;
        push(1'b0, 2'd2, k + 1);
        push(1'b1, 2'd2, k + 2);
        rst_n = 1'b1;
        wait_cyc(k + 1);
        bus.req = '0;
        wait_cyc(k + 3);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_len0_busy: got %b, required 0", bus.busy); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL reset_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_single;
        int k = cyc;
        bus.tone2 = 15'h7FF0; bus.len2 = 8'd2; bus.req = 3'b100;
        push(1'b0, 2'd2, k + 1);
        push(1'b1, 2'd2, k + 41);
        wait_cyc(k + 1);
        bus.req = '0;
        tests++; if (bus.owner !== 2'd2) begin fails++; $display("FAIL single_owner: got %0d, required 2", bus.owner); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
        wait_cyc(k + 32);
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL single_beep_pre: got %b, required 0", beep); end
        wait_cyc(k + 33);
        tests++; if (beep !== 1'b1) begin fails++; $display("FAIL single_beep_rise: got %b, required 1", beep); end
        wait_cyc(k + 41);
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL single_beep_exit: got %b, required 0", beep); end
        wait_cyc(k + 45);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_gap_busy: got %b, required 1", bus.busy); end
        wait_cyc(k + 46);
        tests++; if (bus.busy !== 1'b0 || bus.owner !== 2'd3) begin fails++; $display("FAIL single_idle: got busy %b owner %0d, required 0 3", bus.busy, bus.owner); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_period;
        int k = cyc;
        int off [8] = '{31, 32, 63, 64, 95, 96, 99, 100};
        logic [7:0] val = 8'b0110_0110;
        bus.tone2 = 15'h7FF0; bus.len2 = 8'd5; bus.req = 3'b100;
        push(1'b0, 2'd2, k + 1);
        push(1'b1, 2'd2, k + 101);
        wait_cyc(k + 1);
        bus.req = '0;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(k + 1 + off[i]);
            tests++; if (beep !== val[i]) begin fails++; $display("FAIL period_beep_g%0d: got %b, required %b", off[i], beep, val[i]); end
        end
        wait_cyc(k + 106);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL period_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_simultaneous;
        int k = cyc;
        bus.tone1 = 15'h7FF0; bus.len1 = 8'd1; bus.tone2 = TONE_M3; bus.len2 = 8'd1;
        bus.req = 3'b110;
        push(1'b0, 2'd1, k + 1);
        push(1'b1, 2'd1, k + 21);
        push(1'b0, 2'd2, k + 27);
        push(1'b1, 2'd2, k + 47);
        wait_cyc(k + 1);
        bus.req = 3'b100;
        tests++; if (bus.owner !== 2'd1) begin fails++; $display("FAIL simul_owner1: got %0d, required 1", bus.owner); end
        wait_cyc(k + 26);
        tests++; if (bus.owner !== 2'd3) begin fails++; $display("FAIL simul_owner_idle: got %0d, required 3", bus.owner); end
        wait_cyc(k + 27);
        bus.req = '0;
        tests++; if (bus.owner !== 2'd2) begin fails++; $display("FAIL simul_owner2: got %0d, required 2", bus.owner); end
        wait_cyc(k + 53);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_rest_len0;
        int k = cyc;
        int bad = 0;
        bus.tone0 = TONE_REST; bus.len0 = 8'd3; bus.req = 3'b001;
        push(1'b0, 2'd0, k + 1);
        push(1'b1, 2'd0, k + 61);
        wait_cyc(k + 1);
        bus.req = '0;
        for (int c = k + 1; c <= k + 61; c++) begin
            wait_cyc(c);
            if (beep !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rest_beep: got %0d high cycles, required 0", bad); end
        wait_cyc(k + 67);
        k = cyc;
        bus.len0 = 8'd0; bus.req = 3'b001;
        push(1'b0, 2'd0, k + 1);
        push(1'b1, 2'd0, k + 2);
        wait_cyc(k + 1);
        bus.req = '0;
        wait_cyc(k + 2);
        tests++; if (bus.busy !== 1'b0 || bus.owner !== 2'd3) begin fails++; $display("FAIL len0_idle: got busy %b owner %0d, required 0 3", bus.busy, bus.owner); end
        wait_cyc(k + 4);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rest_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_preempt;
        int k = cyc;
        bus.tone2 = TONE_M5; bus.len2 = 8'd4; bus.req = 3'b100;
        push(1'b0, 2'd2, k + 1);
        wait_cyc(k + 1);
        bus.req = '0;
        wait_cyc(k + 10);
        bus.tone0 = TONE_H1; bus.len0 = 8'd1; bus.req = 3'b001;
`ifdef BEEP_SCHED_PREEMPT_EN
        push(1'b0, 2'd0, k + 11);
        push(1'b1, 2'd0, k + 31);
        wait_cyc(k + 11);
        bus.req = '0;
        tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL preempt_owner: got %0d, required 0", bus.owner); end
        wait_cyc(k + 36);
`else
        push(1'b1, 2'd2, k + 81);
        push(1'b0, 2'd0, k + 87);
        push(1'b1, 2'd0, k + 107);
        wait_cyc(k + 11);
        tests++; if (bus.owner !== 2'd2) begin fails++; $display("FAIL nopreempt_owner: got %0d, required 2", bus.owner); end
        wait_cyc(k + 87);
        bus.req = '0;
        wait_cyc(k + 112);
`endif
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL preempt_idle: got busy %b, required 0", bus.busy); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL preempt_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid;
        int k = cyc;
        bus.tone0 = 15'h7FF0; bus.len0 = 8'd4; bus.req = 3'b001;
        push(1'b0, 2'd0, k + 1);
        wait_cyc(k + 1);
        bus.req = '0;
        wait_cyc(k + 40);
        tests++; if (beep !== 1'b1) begin fails++; $display("FAIL midrst_beep_before: got %b, required 1", beep); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.owner !== 2'd3) begin fails++; $display("FAIL midrst_state: got busy %b owner %0d, required 0 3", bus.busy, bus.owner); end
        tests++; if (bus.gnt !== 3'b000 || bus.done !== 3'b000) begin fails++; $display("FAIL midrst_pulses: got gnt %b done %b, required 000 000", bus.gnt, bus.done); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL midrst_beep: got %b, required 0", beep); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_after: got busy %b, required 0", bus.busy); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL midrst_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_period();
        test_simultaneous();
        test_rest_len0();
        test_preempt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/beep_sched.md
BEEP_SCHED -- requirements
Module: beep_sched

Interface
REQ-001 Parameter CLK_DIV, default 10: clk cycles per tone-counter enable (5 MHz base at 50 MHz clk).
REQ-002 Parameter BEAT_DIV, default 10_000_000: clk cycles per beat (5 Hz).
REQ-003 Parameter GAP_CYC, default 1_000_000: silent clk cycles between consecutive notes.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  3  per-requester level request; bit 0 highest priority (0 alarm, 1 key-click, 2 melody).
REQ-007 tone0/tone1/tone2  in  15 each  tone preset per requester; 0 means rest.
REQ-008 len0/len1/len2  in  8 each  note length in beats per requester.
REQ-009 gnt  out  3  one-hot, one-cycle grant pulse.
REQ-010 done  out  3  one-hot, one-cycle completion pulse.
REQ-011 busy  out  1  high in PLAY or GAP.
REQ-012 owner  out  2  index of current owner; 2'd3 when idle.
REQ-013 beep_out  out  1  buzzer drive.

Function
REQ-014 FSM states IDLE, PLAY, GAP; one note per grant.
REQ-015 IDLE: when any req bit is high, the lowest set index wins; gnt[i] pulses the next cycle, tone_i/len_i are latched on that same edge, and the FSM enters PLAY.
REQ-016 Requester may drop req any time after its gnt pulse; latched tone/len are unaffected.
REQ-017 PLAY lasts exactly len*BEAT_DIV cycles; the beat counter restarts at grant.
REQ-018 done[owner] pulses on the last PLAY cycle; the FSM then enters GAP.
REQ-019 GAP lasts GAP_CYC cycles with beep_out=0; the FSM then returns to IDLE and re-arbitrates, so a held req replays.
REQ-020 len=0: gnt is followed by done on the next cycle, with no sound and no GAP; the FSM returns to IDLE.
REQ-021 Tone generation in PLAY: a 15-bit counter is loaded with the preset at grant and increments once per CLK_DIV enable.
REQ-022 When the counter reaches 15'h7FFF it reloads the preset on the next enable and beep_out toggles.
REQ-023 Resulting beep_out frequency is clk/(CLK_DIV*2*(32768-preset)).
REQ-024 Preset 0 (rest): beep_out is held 0 for the note duration.
REQ-025 beep_out is forced 0 in IDLE and GAP, and on PLAY exit regardless of its phase.
REQ-026 A req arriving in the same cycle as done is not granted until IDLE is reached after GAP.
REQ-027 All beat, gap and tone counters are wide enough for their parameter maximums; no wrap occurs inside a note.

Reset
REQ-028 Asserting rst_n low at any time, including mid-note, immediately forces: state IDLE, gnt=0, done=0, busy=0, owner=2'd3, beep_out=0, all counters 0.
REQ-029 A note aborted by reset produces no done pulse.
REQ-030 First arbitration occurs on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro BEEP_SCHED_PREEMPT_EN defined: in PLAY, a req bit with a lower index than owner aborts the current note.
REQ-032 On preemption the aborted owner receives no done pulse, gnt for the new winner pulses the next cycle, the new tone/len are latched, and GAP is skipped.
REQ-033 Macro BEEP_SCHED_PREEMPT_EN undefined: higher-priority requests wait for the normal done/GAP/IDLE sequence.

Structure
REQ-034 Shared package beep_pkg holds the state enum, the 2'd3 idle-owner code, preset width 15, and named tone-preset constants (e.g. middle 3 = 15'h625F, middle 5 = 15'h6715, high 1 = 15'h6D55).
REQ-035 One sub-module, beep_tone_gen, contains the CLK_DIV prescaler, the preset counter and the beep_out toggle; the scheduler FSM stays in beep_sched.

Verification (CLK_DIV=2, BEAT_DIV=20, GAP_CYC=5)
REQ-036 Single req: req=3'b100, tone2=15'h7FF0, len2=2 -> gnt[2] one cycle after req, done[2] 40 cycles after gnt, beep_out period 2*2*16=64 clk, 5 silent cycles, then IDLE.
REQ-037 Simultaneous req: req=3'b110 -> gnt[1] first; gnt[2] after done[1]+GAP; owner sequence 1, 3, 2.
REQ-038 Rest and zero length: tone0=0, len0=3 -> beep_out stays 0 for 60 cycles with done[0] on the last; then len0=0 -> done[0] the cycle after gnt[0].
REQ-039 Preemption with macro: melody playing, req[0] rises -> no done[2], gnt[0] the next cycle; without macro, gnt[0] comes only after done[2]+5 cycles.
REQ-040 Mid-note reset: rst_n low at beat 1 of a len=4 note -> all outputs take reset values immediately; no done pulse is seen.
